// File: rtl/l15_wake_seq_ctrl.sv
// l15_wake_seq_ctrl
// Sequences Ariane core bring-up on an OpenPiton tile. It holds the core in
// reset through SRAM init, releases it on a wakeup interrupt, gates L1.5
// request valid and tracks outstanding L1.5 transactions. It also runs the
// drained re-reset and idle/resume sequences.
// Optional build macro: L15_WAKE_TIMEOUT_EN. When defined, WAIT_WAKE falls
// through to RUN after TimeoutCycles and flags err_o.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// INIT      | core held in reset while tile SRAMs initialise
// WAIT_WAKE | init done, waiting for power-on wake interrupt
// RUN       | core out of reset, requests flow
// DRAIN     | gate closing, waiting for outstanding returns to reach zero
// HOLD      | core reset asserted for HoldCycles, then back to RUN
// IDLEST    | drained and gated, core not reset, waiting for RESUME
module l15_wake_seq_ctrl #(
    parameter int unsigned InitCycles     = 32768,
    parameter int unsigned HoldCycles     = 16,
    parameter int unsigned MaxOutstanding = 16,
    parameter logic [3:0]  IntRetType     = 4'h7
`ifdef L15_WAKE_TIMEOUT_EN
    ,
    parameter int unsigned TimeoutCycles  = 65536
`endif
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic                                l15_val_i,
    input  logic                                l15_ack_i,
    output logic                                l15_val_o,
    input  logic                                l15_rtrn_val_i,
    input  logic [3:0]                          l15_rtrn_type_i,
    input  logic [17:0]                         l15_rtrn_data_i,
    output logic                                core_rst_no,
    output logic [$clog2(MaxOutstanding):0]     outstanding_o,
    output logic [2:0]                          state_o,
    output logic                                err_o
);

    localparam int unsigned CntW    = $clog2(MaxOutstanding) + 1;
    localparam int unsigned TmrMax0 = (InitCycles > HoldCycles) ? InitCycles : HoldCycles;
`ifdef L15_WAKE_TIMEOUT_EN
    localparam int unsigned TmrMax  = (TmrMax0 > TimeoutCycles) ? TmrMax0 : TimeoutCycles;
`else
    localparam int unsigned TmrMax  = TmrMax0;
`endif
    localparam int unsigned TmrW    = $clog2(TmrMax) + 1;

    typedef enum logic [2:0] {
        ST_INIT      = 3'd0,
        ST_WAIT_WAKE = 3'd1,
        ST_RUN       = 3'd2,
        ST_DRAIN     = 3'd3,
        ST_HOLD      = 3'd4,
        ST_IDLEST    = 3'd5
    } state_e;

    state_e            state_q, state_d;
    logic [TmrW-1:0]   timer_q, timer_d;
    logic [CntW-1:0]   outst_q, outst_d;
    logic              gate_q, gate_d;
    logic              core_rst_q, core_rst_d;
    logic              target_hold_q, target_hold_d;
    logic              wake_pend_q, wake_pend_d;
    logic              err_q, err_d;

    logic is_int, rsp, acc, underflow;
    logic int_wake, int_rrst, int_idle, int_resume;
    logic data_unused;

    // Bits 15:6 of the return word carry nothing this block decodes.
    assign data_unused = ^l15_rtrn_data_i[15:6];

    assign is_int     = l15_rtrn_val_i && (l15_rtrn_type_i == IntRetType);
    assign rsp        = l15_rtrn_val_i && (l15_rtrn_type_i != IntRetType);
    assign int_wake   = is_int && (l15_rtrn_data_i[17:16] == 2'b01) && (l15_rtrn_data_i[5:0] == 6'd1);
    assign int_rrst   = is_int && (l15_rtrn_data_i[17:16] == 2'b01) && (l15_rtrn_data_i[5:0] == 6'd0);
    assign int_idle   = is_int && (l15_rtrn_data_i[17:16] == 2'b10);
    assign int_resume = is_int && (l15_rtrn_data_i[17:16] == 2'b11);

    assign l15_val_o  = l15_val_i && gate_q && (outst_q < CntW'(MaxOutstanding));
    assign acc        = l15_val_o && l15_ack_i;

    assign core_rst_no   = core_rst_q;
    assign outstanding_o = outst_q;
    assign state_o       = state_q;
    assign err_o         = err_q;

    // Outstanding counter; a return with nothing outstanding is a protocol error.
    always_comb begin
        outst_d   = outst_q;
        underflow = 1'b0;
        if (acc && !rsp) begin
            outst_d = outst_q + CntW'(1);
        end else if (rsp && !acc) begin
            if (outst_q == '0) begin
                underflow = 1'b1;
            end else begin
                outst_d = outst_q - CntW'(1);
            end
        end
    end

    // Next-state and registered-output logic for the sequencer.
    always_comb begin
        state_d       = state_q;
        timer_d       = '0;
        gate_d        = gate_q;
        core_rst_d    = core_rst_q;
        target_hold_d = target_hold_q;
        wake_pend_d   = wake_pend_q;
        err_d         = err_q | underflow;
        case (state_q)
            ST_INIT: begin
                if (int_wake) begin
                    wake_pend_d = 1'b1;
                end
                if (timer_q == TmrW'(InitCycles - 1)) begin
                    state_d = ST_WAIT_WAKE;
                end else begin
                    timer_d = timer_q + TmrW'(1);
                end
            end
            ST_WAIT_WAKE: begin
                if (int_wake || wake_pend_q) begin
                    state_d     = ST_RUN;
                    core_rst_d  = 1'b1;
                    gate_d      = 1'b1;
                    wake_pend_d = 1'b0;
`ifdef L15_WAKE_TIMEOUT_EN
                end else if (timer_q == TmrW'(TimeoutCycles - 1)) begin
                    state_d     = ST_RUN;
                    core_rst_d  = 1'b1;
                    gate_d      = 1'b1;
                    wake_pend_d = 1'b0;
                    err_d       = 1'b1;
                end else begin
                    timer_d = timer_q + TmrW'(1);
`endif
                end
            end
            ST_RUN: begin
                if (int_rrst) begin
                    state_d       = ST_DRAIN;
                    target_hold_d = 1'b1;
                end else if (int_idle) begin
                    state_d       = ST_DRAIN;
                    target_hold_d = 1'b0;
                end
            end
            ST_DRAIN: begin
                if (int_rrst) begin
                    target_hold_d = 1'b1;
                end
                // Never drop a valid that is still waiting for its ack.
                if (gate_q && !(l15_val_o && !l15_ack_i)) begin
                    gate_d = 1'b0;
                end
                if (!gate_q && (outst_q == '0)) begin
                    if (target_hold_q || int_rrst) begin
                        state_d    = ST_HOLD;
                        core_rst_d = 1'b0;
                    end else begin
                        state_d = ST_IDLEST;
                    end
                end
            end
            ST_HOLD: begin
                if (timer_q == TmrW'(HoldCycles - 1)) begin
                    state_d    = ST_RUN;
                    core_rst_d = 1'b1;
                    gate_d     = 1'b1;
                end else begin
                    timer_d = timer_q + TmrW'(1);
                end
            end
            ST_IDLEST: begin
                if (int_rrst) begin
                    state_d    = ST_HOLD;
                    core_rst_d = 1'b0;
                end else if (int_resume) begin
                    state_d = ST_RUN;
                    gate_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // State and control registers, asynchronously cleared.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= ST_INIT;
            timer_q       <= '0;
            outst_q       <= '0;
            gate_q        <= 1'b0;
            core_rst_q    <= 1'b0;
            target_hold_q <= 1'b0;
            wake_pend_q   <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            outst_q       <= outst_d;
            gate_q        <= gate_d;
            core_rst_q    <= core_rst_d;
            target_hold_q <= target_hold_d;
            wake_pend_q   <= wake_pend_d;
            err_q         <= err_d;
        end
    end

endmodule
